// File: rtl/read_gather_if.sv
// Request, memory and response signals of read_gather in one bundle.
// The slave modport is the gather block; the master is the requester plus memory.
interface read_gather_if #(
  parameter int ROW_W  = 1024,
  parameter int STRIDE = 8,
  parameter int PLANES = 2,
  parameter int ADDR_W = 7
);
  localparam int PH_W   = (STRIDE > 1) ? $clog2(STRIDE) : 1;
  localparam int PL_W   = (PLANES > 1) ? $clog2(PLANES) : 1;
  localparam int MEM_AW = ADDR_W + $clog2(STRIDE);
  localparam int DATA_W = PLANES * (ROW_W / STRIDE);

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [PH_W-1:0]   req_phase;
  logic              mem_en;
  logic [PL_W-1:0]   mem_plane;
  logic [MEM_AW-1:0] mem_addr;
  logic [ROW_W-1:0]  mem_rdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;

  modport master (
    output req_valid, req_addr, req_phase, mem_rdata, rsp_ready,
    input  req_ready, mem_en, mem_plane, mem_addr, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_addr, req_phase, mem_rdata, rsp_ready,
    output req_ready, mem_en, mem_plane, mem_addr, rsp_valid, rsp_data
  );
endinterface

// File: rtl/read_gather.sv
// Reads one memory row per bit-plane and keeps every STRIDE-th bit into a packed word.
// Optional macro READ_GATHER_PHASE_EN: honour req_phase as the bit offset within the stride.
module read_gather #(
  parameter int ROW_W  = 1024,
  parameter int STRIDE = 8,
  parameter int PLANES = 2,
  parameter int ADDR_W = 7
) (
  input  logic        clk,
  input  logic        rst,
  read_gather_if.slave bus,
  output logic        busy
);
  localparam int PH_W   = (STRIDE > 1) ? $clog2(STRIDE) : 1;
  localparam int PL_W   = (PLANES > 1) ? $clog2(PLANES) : 1;
  localparam int SH     = $clog2(STRIDE);
  localparam int MEM_AW = ADDR_W + SH;
  localparam int SEG    = ROW_W / STRIDE;
  localparam int DATA_W = PLANES * SEG;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, RESP} state_t;

  state_t            r_state;
  logic [PL_W-1:0]   r_p;
  logic              r_req_ready;
  logic              r_busy;
  logic              r_mem_en;
  logic [PL_W-1:0]   r_mem_plane;
  logic [MEM_AW-1:0] r_mem_addr;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_data;
  logic [PH_W-1:0]   w_phase;
  logic [PL_W-1:0]   w_prev_p;

`ifdef READ_GATHER_PHASE_EN
  logic [PH_W-1:0] r_phase;
  assign w_phase = r_phase;
`else
  logic w_unused_phase;
  assign w_unused_phase = ^bus.req_phase;
  assign w_phase        = '0;
`endif

  // Data for a read arrives one edge after its strobe, so ISSUE stores the previous plane.
  assign w_prev_p = r_p - 1'b1;

  function automatic logic [SEG-1:0] gather(input logic [ROW_W-1:0] row,
                                            input logic [PH_W-1:0]  ph);
    logic [SEG-1:0] g;
    int             off;
    off = (STRIDE > 1) ? int'(ph) : 0;
    for (int i = 0; i < SEG; i++) g[i] = row[i*STRIDE + off];
    return g;
  endfunction

  // NOTE: every register here, including the gathered word, is cleared by the async
  //       reset and updated with <= so all state moves together on the clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_p         <= '0;
      r_req_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_mem_en    <= 1'b0;
      r_mem_plane <= '0;
      r_mem_addr  <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
`ifdef READ_GATHER_PHASE_EN
      r_phase     <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.req_valid) begin
`ifdef READ_GATHER_PHASE_EN
            r_phase     <= bus.req_phase;
`endif
            r_p         <= '0;
            r_state     <= ISSUE;
            r_req_ready <= 1'b0;
            r_busy      <= 1'b1;
            r_mem_en    <= 1'b1;
            r_mem_plane <= '0;
            r_mem_addr  <= MEM_AW'(bus.req_addr) << SH;
          end
        end
        ISSUE: begin
          if (r_p != '0) r_rsp_data[w_prev_p*SEG +: SEG] <= gather(bus.mem_rdata, w_phase);
          if (r_p == PL_W'(PLANES - 1)) begin
            r_state  <= DRAIN;
            r_mem_en <= 1'b0;
          end else begin
            r_p         <= r_p + 1'b1;
            r_mem_plane <= r_p + 1'b1;
          end
        end
        DRAIN: begin
          r_rsp_data[(PLANES-1)*SEG +: SEG] <= gather(bus.mem_rdata, w_phase);
          r_state     <= RESP;
          r_rsp_valid <= 1'b1;
        end
        RESP: begin
          // Ready rises only after the handshake edge, so a new request waits one cycle.
          if (bus.rsp_ready) begin
            r_state     <= IDLE;
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_busy      <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = r_req_ready;
  assign bus.mem_en    = r_mem_en;
  assign bus.mem_plane = r_mem_plane;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_data  = r_rsp_data;
  assign busy          = r_busy;
endmodule

// File: tb/tb_read_gather.sv
// Scoreboard bench for read_gather: default instance plus a PLANES=4/STRIDE=4/ROW_W=64 one.
module tb_read_gather;
  localparam int ROW_W = 1024, STRIDE = 8, PLANES = 2, ADDR_W = 7;
  localparam int SEG = ROW_W / STRIDE, DW = PLANES * SEG;
  localparam int S_ROW_W = 64, S_STRIDE = 4, S_PLANES = 4, S_SEG = 16, S_DW = 64;

  logic clk = 1'b0;
  logic rst;
  logic busy, busy_s;
  int   total = 0;
  int   bad   = 0;

  logic [ROW_W-1:0]   rows   [PLANES];
  logic [S_ROW_W-1:0] rows_s [S_PLANES];
  logic [DW-1:0]      exp_q   [$];
  logic [S_DW-1:0]    exp_s_q [$];

  read_gather_if #(.ROW_W(ROW_W), .STRIDE(STRIDE), .PLANES(PLANES), .ADDR_W(ADDR_W)) bus ();
  read_gather_if #(.ROW_W(S_ROW_W), .STRIDE(S_STRIDE), .PLANES(S_PLANES), .ADDR_W(ADDR_W)) bus_s ();

  read_gather #(.ROW_W(ROW_W), .STRIDE(STRIDE), .PLANES(PLANES), .ADDR_W(ADDR_W)) u_dut (
    .clk(clk), .rst(rst), .bus(bus), .busy(busy));
  read_gather #(.ROW_W(S_ROW_W), .STRIDE(S_STRIDE), .PLANES(S_PLANES), .ADDR_W(ADDR_W)) u_small (
    .clk(clk), .rst(rst), .bus(bus_s), .busy(busy_s));

  always #5 clk = ~clk;

  // Memory models: row data valid the cycle after the strobe is sampled.
  always @(posedge clk) if (bus.mem_en) bus.mem_rdata <= rows[bus.mem_plane];
  always @(posedge clk) if (bus_s.mem_en) bus_s.mem_rdata <= rows_s[bus_s.mem_plane];

  function automatic int eff_phase(input int ph);
`ifdef READ_GATHER_PHASE_EN
    return ph;
`else
    return 0;
`endif
  endfunction

  function automatic logic [DW-1:0] model(input int ph);
    logic [DW-1:0] d;
    d = '0;
    for (int p = 0; p < PLANES; p++)
      for (int i = 0; i < SEG; i++) d[p*SEG + i] = rows[p][i*STRIDE + eff_phase(ph)];
    return d;
  endfunction

  function automatic logic [S_DW-1:0] model_s(input int ph);
    logic [S_DW-1:0] d;
    d = '0;
    for (int p = 0; p < S_PLANES; p++)
      for (int i = 0; i < S_SEG; i++) d[p*S_SEG + i] = rows_s[p][i*S_STRIDE + eff_phase(ph)];
    return d;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_rand();
    for (int p = 0; p < PLANES; p++)
      for (int w = 0; w < ROW_W / 32; w++) rows[p][w*32 +: 32] = $urandom();
  endtask

  // Full transaction on the default instance starting from IDLE.
  task automatic run_req(input int addr, input int ph);
    int n;
    logic [DW-1:0] want;
    bus.req_valid = 1'b1;
    bus.req_addr  = ADDR_W'(addr);
    bus.req_phase = 3'(ph);
    exp_q.push_back(model(ph));
    tick();
    bus.req_valid = 1'b0;
    total++; if (bus.mem_addr !== 10'(addr * STRIDE)) begin bad++; $display("FAIL req_mem_addr: got %0d want %0d", bus.mem_addr, addr * STRIDE); end
    n = 0;
    while (!bus.rsp_valid && n < 20) begin tick(); n++; end
    total++; if (n != PLANES + 1) begin bad++; $display("FAIL req_latency: got %0d want %0d", n, PLANES + 1); end
    want = exp_q.pop_front();
    total++; if (bus.rsp_data !== want) begin bad++; $display("FAIL req_data: got %0h want %0h", bus.rsp_data, want); end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL req_idle: got busy=%0b want 0", busy); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    total++; if (busy !== 1'b0 || bus.mem_en !== 1'b0 || bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_ctrl: got busy=%0b en=%0b vld=%0b want 0", busy, bus.mem_en, bus.rsp_valid); end
    total++; if (bus.mem_addr !== '0 || bus.mem_plane !== '0) begin bad++; $display("FAIL reset_addr: got addr=%0d plane=%0d want 0", bus.mem_addr, bus.mem_plane); end
    total++; if (bus.rsp_data !== '0) begin bad++; $display("FAIL reset_data: got %0h want 0", bus.rsp_data); end
    tick();
    rst = 1'b0;
    tick();
    total++; if (bus.req_ready !== 1'b1 || bus_s.req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %0b/%0b want 1", bus.req_ready, bus_s.req_ready); end
  endtask

  task automatic test_basic();
    logic [DW-1:0] want;
    logic [DW-1:0] lit;
    for (int i = 0; i < ROW_W; i++) rows[0][i] = (i % STRIDE == 0);
    rows[1] = '0;
    lit = '0;
    for (int i = 0; i < SEG; i++) lit[i] = 1'b1;
    bus.req_valid = 1'b1; bus.req_addr = 7'd5; bus.req_phase = 3'd0;
    exp_q.push_back(model(0));
    tick();
    bus.req_valid = 1'b0;
    total++; if (bus.mem_en !== 1'b1 || bus.mem_plane !== 1'b0 || bus.mem_addr !== 10'd40) begin bad++; $display("FAIL basic_issue0: got en=%0b plane=%0d addr=%0d want 1/0/40", bus.mem_en, bus.mem_plane, bus.mem_addr); end
    total++; if (busy !== 1'b1 || bus.req_ready !== 1'b0) begin bad++; $display("FAIL basic_busy: got busy=%0b rdy=%0b want 1/0", busy, bus.req_ready); end
    tick();
    total++; if (bus.mem_en !== 1'b1 || bus.mem_plane !== 1'b1 || bus.mem_addr !== 10'd40) begin bad++; $display("FAIL basic_issue1: got en=%0b plane=%0d addr=%0d want 1/1/40", bus.mem_en, bus.mem_plane, bus.mem_addr); end
    total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL basic_early1: got %0b want 0", bus.rsp_valid); end
    tick();
    total++; if (bus.mem_en !== 1'b0 || bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL basic_drain: got en=%0b vld=%0b want 0/0", bus.mem_en, bus.rsp_valid); end
    tick();
    total++; if (bus.rsp_valid !== 1'b1) begin bad++; $display("FAIL basic_valid: got %0b want 1", bus.rsp_valid); end
    want = exp_q.pop_front();
    total++; if (bus.rsp_data !== want) begin bad++; $display("FAIL basic_data: got %0h want %0h", bus.rsp_data, want); end
    total++; if (bus.rsp_data !== lit) begin bad++; $display("FAIL basic_pattern: got %0h want %0h", bus.rsp_data, lit); end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    total++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL basic_done: got vld=%0b rdy=%0b busy=%0b want 0/1/0", bus.rsp_valid, bus.req_ready, busy); end
    total++; if (bus.rsp_data !== want) begin bad++; $display("FAIL basic_retain: got %0h want %0h", bus.rsp_data, want); end
  endtask

  task automatic test_phase();
    logic [DW-1:0] lit;
    rows[0] = '0;
    rows[1] = '0;
    rows[1][1019] = 1'b1;
    lit = '0;
`ifdef READ_GATHER_PHASE_EN
    lit[DW-1] = 1'b1;
`endif
    run_req(9, 3);
    total++; if (bus.rsp_data !== lit) begin bad++; $display("FAIL phase_bit: got %0h want %0h", bus.rsp_data, lit); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 4; k++) begin
      fill_rand();
      run_req($urandom_range(0, 127), $urandom_range(0, 7));
    end
  endtask

  task automatic test_backpressure();
    int n;
    logic [DW-1:0] want;
    fill_rand();
    bus.req_valid = 1'b1; bus.req_addr = 7'd3; bus.req_phase = 3'd2;
    exp_q.push_back(model(2));
    tick();
    bus.req_valid = 1'b0;
    n = 0;
    while (!bus.rsp_valid && n < 20) begin tick(); n++; end
    want = exp_q.pop_front();
    bus.req_addr = 7'd77;
    for (int k = 0; k < 10; k++) begin
      total++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== want) begin bad++; $display("FAIL bp_hold: got vld=%0b data=%0h want 1/%0h", bus.rsp_valid, bus.rsp_data, want); end
      total++; if (bus.req_ready !== 1'b0 || bus.mem_en !== 1'b0) begin bad++; $display("FAIL bp_ignore: got rdy=%0b en=%0b want 0/0", bus.req_ready, bus.mem_en); end
      bus.req_valid = 1'b1;
      tick();
    end
    bus.rsp_ready = 1'b1;
    tick();
    total++; if (busy !== 1'b0 || bus.req_ready !== 1'b1 || bus.mem_en !== 1'b0 || bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL bp_release: got busy=%0b rdy=%0b en=%0b vld=%0b want 0/1/0/0", busy, bus.req_ready, bus.mem_en, bus.rsp_valid); end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    tick();
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL bp_not_queued: got busy=%0b want 0", busy); end
  endtask

  task automatic test_reset_mid();
    logic seen;
    fill_rand();
    bus.req_valid = 1'b1; bus.req_addr = 7'd20; bus.req_phase = 3'd0;
    exp_q.push_back(model(0));
    tick();
    bus.req_valid = 1'b0;
    tick();
    total++; if (bus.mem_plane !== 1'b1 || bus.mem_en !== 1'b1) begin bad++; $display("FAIL rmid_pre: got plane=%0d en=%0b want 1/1", bus.mem_plane, bus.mem_en); end
    rst = 1'b1;
    #1;
    total++; if (bus.mem_en !== 1'b0 || bus.rsp_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rmid_async: got en=%0b vld=%0b busy=%0b want 0/0/0", bus.mem_en, bus.rsp_valid, busy); end
    total++; if (bus.rsp_data !== '0) begin bad++; $display("FAIL rmid_data: got %0h want 0", bus.rsp_data); end
    void'(exp_q.pop_back());
    tick();
    rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (bus.rsp_valid || bus.mem_en) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL rmid_quiet: got activity=%0b want 0", seen); end
    fill_rand();
    run_req(33, 1);
  endtask

  task automatic test_back_to_back();
    int n;
    logic [DW-1:0] want;
    fill_rand();
    bus.rsp_ready = 1'b1;
    bus.req_valid = 1'b1; bus.req_addr = 7'd0; bus.req_phase = 3'd0;
    exp_q.push_back(model(0));
    tick();
    total++; if (bus.mem_addr !== 10'd0 || bus.mem_en !== 1'b1) begin bad++; $display("FAIL b2b_first: got addr=%0d en=%0b want 0/1", bus.mem_addr, bus.mem_en); end
    bus.req_addr = 7'd127;
    exp_q.push_back(model(0));
    n = 0;
    while (!bus.rsp_valid && n < 20) begin tick(); n++; end
    want = exp_q.pop_front();
    total++; if (bus.rsp_data !== want) begin bad++; $display("FAIL b2b_data1: got %0h want %0h", bus.rsp_data, want); end
    tick();
    total++; if (busy !== 1'b0 || bus.req_ready !== 1'b1) begin bad++; $display("FAIL b2b_gap: got busy=%0b rdy=%0b want 0/1", busy, bus.req_ready); end
    tick();
    bus.req_valid = 1'b0;
    total++; if (busy !== 1'b1 || bus.mem_en !== 1'b1 || bus.mem_addr !== 10'd1016) begin bad++; $display("FAIL b2b_second: got busy=%0b en=%0b addr=%0d want 1/1/1016", busy, bus.mem_en, bus.mem_addr); end
    n = 0;
    while (!bus.rsp_valid && n < 20) begin tick(); n++; end
    total++; if (n != PLANES + 1) begin bad++; $display("FAIL b2b_latency: got %0d want %0d", n, PLANES + 1); end
    want = exp_q.pop_front();
    total++; if (bus.rsp_data !== want) begin bad++; $display("FAIL b2b_data2: got %0h want %0h", bus.rsp_data, want); end
    tick();
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_small();
    int addr;
    int ph;
    logic [S_DW-1:0] want;
    for (int r = 0; r < 3; r++) begin
      for (int p = 0; p < S_PLANES; p++) begin
        rows_s[p][31:0]  = $urandom();
        rows_s[p][63:32] = $urandom();
      end
      addr = $urandom_range(0, 127);
      ph   = $urandom_range(0, 3);
      bus_s.req_valid = 1'b1; bus_s.req_addr = ADDR_W'(addr); bus_s.req_phase = 2'(ph);
      exp_s_q.push_back(model_s(ph));
      tick();
      bus_s.req_valid = 1'b0;
      for (int k = 0; k < S_PLANES; k++) begin
        total++; if (bus_s.mem_en !== 1'b1 || bus_s.mem_plane !== 2'(k) || bus_s.mem_addr !== 9'(addr * S_STRIDE)) begin bad++; $display("FAIL small_issue%0d: got en=%0b plane=%0d addr=%0d want 1/%0d/%0d", k, bus_s.mem_en, bus_s.mem_plane, bus_s.mem_addr, k, addr * S_STRIDE); end
        tick();
      end
      total++; if (bus_s.mem_en !== 1'b0 || bus_s.rsp_valid !== 1'b0) begin bad++; $display("FAIL small_drain: got en=%0b vld=%0b want 0/0", bus_s.mem_en, bus_s.rsp_valid); end
      tick();
      want = exp_s_q.pop_front();
      total++; if (bus_s.rsp_valid !== 1'b1 || bus_s.rsp_data !== want) begin bad++; $display("FAIL small_rsp: got vld=%0b data=%0h want 1/%0h", bus_s.rsp_valid, bus_s.rsp_data, want); end
      bus_s.rsp_ready = 1'b1;
      tick();
      bus_s.rsp_ready = 1'b0;
      total++; if (busy_s !== 1'b0) begin bad++; $display("FAIL small_idle: got busy=%0b want 0", busy_s); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.req_valid = 1'b0; bus.req_addr = '0; bus.req_phase = '0; bus.rsp_ready = 1'b0;
    bus_s.req_valid = 1'b0; bus_s.req_addr = '0; bus_s.req_phase = '0; bus_s.rsp_ready = 1'b0;
    for (int p = 0; p < PLANES; p++) rows[p] = '0;
    for (int p = 0; p < S_PLANES; p++) rows_s[p] = '0;
    test_reset();
    test_basic();
    test_phase();
    test_random();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_small();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
